// File: rtl/multiple_adder_naive_4x32.sv
// Pipelined four-operand unsigned adder: final_sum = x + y + z + w.
// Naive two-level tree: two pairwise adds registered, then one final add registered.
// Optional build macro MULTI_ADDER_INREG_EN adds an input register stage (latency 2 -> 3).
// Data registers load every cycle; only the valid bit qualifies final_sum.
module multiple_adder_naive_4x32 #(
  parameter int WIDTH = 32,
  parameter int SUM_W = WIDTH + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  output logic [SUM_W-1:0] final_sum
);

  // Operands as seen by the stage-1 adders
  logic [WIDTH-1:0] src_x;
  logic [WIDTH-1:0] src_y;
  logic [WIDTH-1:0] src_z;
  logic [WIDTH-1:0] src_w;
  logic             src_v;

`ifdef MULTI_ADDER_INREG_EN
  logic [WIDTH-1:0] in_x_q;
  logic [WIDTH-1:0] in_y_q;
  logic [WIDTH-1:0] in_z_q;
  logic [WIDTH-1:0] in_w_q;
  logic             in_v_q;

  // Input register stage: capture operands and valid before the adder tree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x_q <= '0;
      in_y_q <= '0;
      in_z_q <= '0;
      in_w_q <= '0;
      in_v_q <= 1'b0;
    end else begin
      in_x_q <= x;
      in_y_q <= y;
      in_z_q <= z;
      in_w_q <= w;
      in_v_q <= in_valid;
    end
  end

  // Stage-1 adders are fed from the input registers
  always_comb begin
    src_x = in_x_q;
    src_y = in_y_q;
    src_z = in_z_q;
    src_w = in_w_q;
    src_v = in_v_q;
  end
`else
  // Stage-1 adders are fed straight from the ports
  always_comb begin
    src_x = x;
    src_y = y;
    src_z = z;
    src_w = w;
    src_v = in_valid;
  end
`endif

  logic [WIDTH:0]   s1_xy_d, s1_xy_q;
  logic [WIDTH:0]   s1_zw_d, s1_zw_q;
  logic             s1_v_q;
  logic [WIDTH+1:0] s2_tree;
  logic [SUM_W-1:0] s2_sum_d, s2_sum_q;
  logic             s2_v_q;

  // Level-1 pairwise sums; the carry out lands in bit WIDTH
  always_comb begin
    s1_xy_d = {1'b0, src_x} + {1'b0, src_y};
    s1_zw_d = {1'b0, src_z} + {1'b0, src_w};
  end

  // Stage-1 register: pairwise sums and their valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_xy_q <= '0;
      s1_zw_q <= '0;
      s1_v_q  <= 1'b0;
    end else begin
      s1_xy_q <= s1_xy_d;
      s1_zw_q <= s1_zw_d;
      s1_v_q  <= src_v;
    end
  end

  // Level-2 final add, zero-extended to the result width
  always_comb begin
    s2_tree  = {1'b0, s1_xy_q} + {1'b0, s1_zw_q};
    s2_sum_d = {{(SUM_W-WIDTH-2){1'b0}}, s2_tree};
  end

  // Stage-2 register: final sum and its valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sum_q <= '0;
      s2_v_q   <= 1'b0;
    end else begin
      s2_sum_q <= s2_sum_d;
      s2_v_q   <= s1_v_q;
    end
  end

  assign final_sum = s2_sum_q;
  assign out_valid = s2_v_q;

endmodule

// File: tb/tb_multiple_adder_naive_4x32.sv
// Directed self-checking bench for multiple_adder_naive_4x32.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_multiple_adder_naive_4x32;

`ifdef MULTI_ADDER_INREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x, y, z, w;
  logic        out_valid;
  logic [34:0] final_sum;

  int tests;
  int fails;

  // Hand-computed vector table
  logic [31:0] vx [4];
  logic [31:0] vy [4];
  logic [31:0] vz [4];
  logic [31:0] vw [4];
  logic [34:0] vs [4];

  multiple_adder_naive_4x32 #(.WIDTH(32), .SUM_W(35)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .z         (z),
    .w         (w),
    .out_valid (out_valid),
    .final_sum (final_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    in_valid = 1'b0;
    x = 'x; y = 'x; z = 'x; w = 'x;
  endtask

  task automatic drive_set(input int i);
    in_valid = 1'b1;
    x = vx[i]; y = vy[i]; z = vz[i]; w = vw[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_set(3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || final_sum !== 35'd0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: out_valid=%b final_sum=0x%0h, want 0 / 0x0", c, out_valid, final_sum);
      end
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 1; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_release cyc%0d: out_valid=%b, want 0", c, out_valid);
      end
    end
  endtask

  // Each vector alone: check latency (invalid one cycle early), value, and single-cycle valid
  task automatic test_vectors();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_set(i);
      for (int c = 1; c <= LAT + 1; c++) begin
        @(negedge clk);
        drive_idle();
        tests++;
        if (c == LAT) begin
          if (out_valid !== 1'b1 || final_sum !== vs[i]) begin
            fails++;
            $display("FAIL vector%0d: out_valid=%b final_sum=0x%0h, want 1 / 0x%0h", i, out_valid, final_sum, vs[i]);
          end
        end else if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL vector%0d_latency cyc%0d: out_valid=%b, want 0", i, c, out_valid);
        end
      end
      tests++;
      if (final_sum[34] !== 1'b0) begin
        fails++;
        $display("FAIL vector%0d_msb: final_sum[34]=%b, want 0", i, final_sum[34]);
      end
    end
  endtask

  // Four sets back to back, then a pattern with a one-cycle input bubble
  task automatic test_back_to_back();
    int pv [6];
    int ps [6];
    pv = '{1, 1, 1, 1, 0, 0};
    ps = '{0, 1, 2, 3, 0, 0};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        pv = '{1, 0, 1, 1, 0, 0};
        ps = '{3, 0, 1, 2, 0, 0};
      end
      @(negedge clk);
      for (int c = 0; c < 6 + LAT; c++) begin
        if (c >= LAT) begin
          tests++;
          if (pv[c-LAT] == 1) begin
            if (out_valid !== 1'b1 || final_sum !== vs[ps[c-LAT]]) begin
              fails++;
              $display("FAIL stream%0d slot%0d: out_valid=%b final_sum=0x%0h, want 1 / 0x%0h",
                       pass, c - LAT, out_valid, final_sum, vs[ps[c-LAT]]);
            end
          end else if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream%0d bubble slot%0d: out_valid=%b, want 0", pass, c - LAT, out_valid);
          end
        end
        if (c < 6 && pv[c] == 1) drive_set(ps[c]);
        else drive_idle();
        @(negedge clk);
      end
    end
  endtask

  // Reset while later sets are in flight: outputs clear at once, discarded sets never emerge
  task automatic test_midstream_reset();
    @(negedge clk);
    for (int c = 0; c < LAT; c++) begin
      if (c < 3) drive_set(c + 1);
      else drive_idle();
      @(negedge clk);
    end
    drive_idle();
    tests++;
    if (out_valid !== 1'b1 || final_sum !== vs[1]) begin
      fails++;
      $display("FAIL midrst_first: out_valid=%b final_sum=0x%0h, want 1 / 0x%0h", out_valid, final_sum, vs[1]);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || final_sum !== 35'd0) begin
      fails++;
      $display("FAIL midrst_async: out_valid=%b final_sum=0x%0h, want 0 / 0x0", out_valid, final_sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst_discard cyc%0d: out_valid=%b, want 0", c, out_valid);
      end
    end
    drive_set(0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      drive_idle();
      tests++;
      if (c < LAT && out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst_relatency cyc%0d: out_valid=%b, want 0", c, out_valid);
      end else if (c == LAT && (out_valid !== 1'b1 || final_sum !== vs[0])) begin
        fails++;
        $display("FAIL midrst_resume: out_valid=%b final_sum=0x%0h, want 1 / 0x%0h", out_valid, final_sum, vs[0]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vx[0] = 32'h3;        vy[0] = 32'hA;        vz[0] = 32'h1;        vw[0] = 32'h2;        vs[0] = 35'h10;
    vx[1] = 32'hAAAAAAAA; vy[1] = 32'h55555555; vz[1] = 32'hAAAAAAAA; vw[1] = 32'h55555555; vs[1] = 35'h1_FFFF_FFFE;
    vx[2] = 32'hFFFFFFFF; vy[2] = 32'h1;        vz[2] = 32'h0;        vw[2] = 32'h0;        vs[2] = 35'h1_0000_0000;
    vx[3] = 32'hFFFFFFFF; vy[3] = 32'hFFFFFFFF; vz[3] = 32'hFFFFFFFF; vw[3] = 32'hFFFFFFFF; vs[3] = 35'h3_FFFF_FFFC;
    drive_idle();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
